wb_trace_collector: RTL and testbench

//  Synthesizable observer for the pipelined mips core. Captures GRF writes (W stage) and DM writes
//  (M stage) as trace records, buffers them in an internal FIFO and drains them over a valid/ready

---
 rtl/trace_pkg.sv | 41 ++++
 rtl/trace_fifo.sv | 45 ++++
 rtl/wb_trace_collector.sv | 116 +++++++++++
 tb/tb_wb_trace_collector.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Trace record layout shared by the collector and its FIFO.
// Optional macro TRACE_SEQ_EN appends a 32-bit sequence tag above the base record.
package trace_pkg;

  localparam logic TR_TYPE_GRF = 1'b0;
  localparam logic TR_TYPE_DM  = 1'b1;

  localparam int TR_DATA_LSB = 0;
  localparam int TR_ADDR_LSB = 32;
  localparam int TR_PC_LSB   = 64;
  localparam int TR_TYPE_BIT = 96;
  localparam int TR_BASE_W   = 97;

`ifdef TRACE_SEQ_EN
  localparam int TR_SEQ_LSB  = 97;
  localparam int TR_REC_W    = 129;
`else
  localparam int TR_REC_W    = 97;
`endif

  // Field order matches the *_LSB offsets above (data in the low word).
  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } tr_base_t;

  function automatic tr_base_t tr_make(input logic        typ,
                                       input logic [31:0] pc,
                                       input logic [31:0] addr,
                                       input logic [31:0] data);
    tr_base_t r;
    r.typ  = typ;
    r.pc   = pc;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push / single-pop synchronous FIFO; slot 0 is always written before slot 1.
// Storage is not reset; only pointers and occupancy are.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 5,
  parameter int W     = TR_REC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    push_cnt,
  input  logic [W-1:0]  wdata0,
  input  logic [W-1:0]  wdata1,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr] <= wdata0;
    if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wdata1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wb_trace_collector.sv
// Observes GRF (W stage) and DM (M stage) writes, buffers them as trace records and streams them out.
// Optional macro TRACE_SEQ_EN adds out_seq, a push-order tag on every accepted record.
module wb_trace_collector
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [31:0]   grf_pc,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wdata,
  input  logic          dm_we,
  input  logic [31:0]   dm_pc,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_type,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
`ifdef TRACE_SEQ_EN
  output logic [31:0]   out_seq,
`endif
  output logic          overflow,
  output logic [CW-1:0] level
);

  logic                grf_vld_p0;
  logic                dm_vld_p0;
  logic [1:0]          need_p0;
  logic [1:0]          push_cnt_p0;
  logic                drop_p0;
  logic [CW-1:0]       count;
  logic [CW-1:0]       free_p0;
  tr_base_t            grf_rec_p0;
  tr_base_t            dm_rec_p0;
  tr_base_t            slot0_base_p0;
  logic [TR_REC_W-1:0] slot0_p0;
  logic [TR_REC_W-1:0] slot1_p0;
  logic [TR_REC_W-1:0] head;
  tr_base_t            head_base;
  logic                pop;

  // Capture stage: filter, order (GRF is the older instruction) and apply drop policy
  assign grf_vld_p0 = grf_we && (grf_addr != 5'd0);
  assign dm_vld_p0  = dm_we;
  assign need_p0    = {1'b0, grf_vld_p0} + {1'b0, dm_vld_p0};

  // Space is judged on the pre-pop occupancy; a same-cycle pop does not help.
  assign free_p0 = CW'(DEPTH) - count;

  always_comb begin
    push_cnt_p0 = need_p0;
    if (free_p0 < CW'(need_p0)) push_cnt_p0 = free_p0[1:0];
  end

  assign drop_p0 = (push_cnt_p0 != need_p0);

  assign grf_rec_p0    = tr_make(TR_TYPE_GRF, grf_pc, {27'd0, grf_addr}, grf_wdata);
  assign dm_rec_p0     = tr_make(TR_TYPE_DM, dm_pc, dm_addr, dm_wdata);
  assign slot0_base_p0 = grf_vld_p0 ? grf_rec_p0 : dm_rec_p0;

`ifdef TRACE_SEQ_EN
  logic [31:0] seq_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seq_cnt <= '0;
    else       seq_cnt <= seq_cnt + 32'(push_cnt_p0);
  end

  assign slot0_p0 = {seq_cnt, slot0_base_p0};
  assign slot1_p0 = {seq_cnt + 32'd1, dm_rec_p0};
`else
  assign slot0_p0 = slot0_base_p0;
  assign slot1_p0 = dm_rec_p0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop_p0) overflow <= 1'b1;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .W     (TR_REC_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_cnt (push_cnt_p0),
    .wdata0   (slot0_p0),
    .wdata1   (slot1_p0),
    .pop      (pop),
    .rdata    (head),
    .count    (count)
  );

  // Output stage: head fields are forced to zero while nothing is buffered
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign level     = count;
  assign head_base = head[TR_BASE_W-1:0];

  assign out_type = out_valid ? head_base.typ  : 1'b0;
  assign out_pc   = out_valid ? head_base.pc   : 32'd0;
  assign out_addr = out_valid ? head_base.addr : 32'd0;
  assign out_data = out_valid ? head_base.data : 32'd0;
`ifdef TRACE_SEQ_EN
  assign out_seq  = out_valid ? head[TR_REC_W-1:TR_SEQ_LSB] : 32'd0;
`endif

endmodule

// File: tb/tb_wb_trace_collector.sv
// Directed bench for wb_trace_collector (DEPTH=16); TRACE_SEQ_EN enables the sequence-tag scenario.
module tb_wb_trace_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_type;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        overflow;
  logic [4:0]  level;
`ifdef TRACE_SEQ_EN
  logic [31:0] out_seq;
`endif

  int checks   = 0;
  int failures = 0;

  wb_trace_collector #(.DEPTH(16), .CW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_wdata (grf_wdata),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
`ifdef TRACE_SEQ_EN
    .out_seq   (out_seq),
`endif
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wdata = '0;
    dm_we  = 1'b0; dm_pc  = '0; dm_addr  = '0; dm_wdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: valid=%b level=%0d ovf=%b, want 0/0/0", out_valid, level, overflow);
    end
    checks++;
    if (out_type !== 1'b0 || out_pc !== 32'd0 || out_addr !== 32'd0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_fields: type=%b pc=%h addr=%h data=%h, want all 0",
               out_type, out_pc, out_addr, out_data);
    end
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    grf_we = 1'b1; grf_addr = 5'd8; grf_wdata = 32'h1234; grf_pc = 32'h3000;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_type !== 1'b0 || out_addr !== 32'd8 ||
        out_data !== 32'h1234 || out_pc !== 32'h3000) begin
      failures++;
      $display("FAIL single_rec: v=%b t=%b a=%h d=%h pc=%h, want 1 0 8 1234 3000",
               out_valid, out_type, out_addr, out_data, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      failures++;
      $display("FAIL single_drained: valid=%b level=%0d, want 0/0", out_valid, level);
    end
  endtask

  task automatic test_dual_push();
    out_ready = 1'b0;
    grf_we = 1'b1; grf_addr = 5'd2; grf_wdata = 32'hA; grf_pc = 32'h3004;
    dm_we  = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hB; dm_pc = 32'h3008;
    tick();
    idle_inputs();
    checks++;
    if (level !== 5'd2) begin
      failures++;
      $display("FAIL dual_level: level=%0d, want 2", level);
    end
    checks++;
    if (out_type !== 1'b0 || out_addr !== 32'd2 || out_data !== 32'hA || out_pc !== 32'h3004) begin
      failures++;
      $display("FAIL dual_first_grf: t=%b a=%h d=%h pc=%h, want 0 2 a 3004",
               out_type, out_addr, out_data, out_pc);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_type !== 1'b1 || out_addr !== 32'h10 ||
        out_data !== 32'hB || out_pc !== 32'h3008 || level !== 5'd1) begin
      failures++;
      $display("FAIL dual_second_dm: v=%b t=%b a=%h d=%h pc=%h lvl=%0d, want 1 1 10 b 3008 1",
               out_valid, out_type, out_addr, out_data, out_pc, level);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dual_drained: valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_filter();
    grf_we = 1'b1; grf_addr = 5'd0; grf_wdata = 32'hFFFF; grf_pc = 32'h300C;
    tick();
    idle_inputs();
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL filter_r0: level=%0d valid=%b ovf=%b, want 0/0/0", level, out_valid, overflow);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      grf_we = 1'b1; grf_addr = 5'(i % 31 + 1); grf_wdata = 32'h100 + 32'(i);
      grf_pc = 32'h4000 + 32'(4 * i);
      tick();
    end
    idle_inputs();
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_level_ovf: level=%0d ovf=%b, want 16/1", level, overflow);
    end
    checks++;
    if (out_data !== 32'h100 || out_addr !== 32'd1 || out_pc !== 32'h4000) begin
      failures++;
      $display("FAIL full_head: d=%h a=%h pc=%h, want 100 1 4000", out_data, out_addr, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // level 15: GRF fits, DM must be dropped
    grf_we = 1'b1; grf_addr = 5'd20; grf_wdata = 32'h500; grf_pc = 32'h5000;
    dm_we  = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h600; dm_pc = 32'h5004;
    tick();
    idle_inputs();
    checks++;
    if (level !== 5'd16 || out_data !== 32'h101) begin
      failures++;
      $display("FAIL partial_push: level=%0d head=%h, want 16/101", level, out_data);
    end
    // full with simultaneous pop: push is still refused
    out_ready = 1'b1;
    grf_we = 1'b1; grf_addr = 5'd21; grf_wdata = 32'h700; grf_pc = 32'h6000;
    tick();
    idle_inputs();
    checks++;
    if (level !== 5'd15 || out_data !== 32'h102) begin
      failures++;
      $display("FAIL full_pop_push: level=%0d head=%h, want 15/102", level, out_data);
    end
    for (int i = 2; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(i) || out_type !== 1'b0) begin
        failures++;
        $display("FAIL drain_%0d: v=%b d=%h t=%b, want 1 %h 0", i, out_valid, out_data, out_type,
                 32'h100 + 32'(i));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h500 || out_addr !== 32'd20 || out_type !== 1'b0) begin
      failures++;
      $display("FAIL drain_kept_grf: v=%b d=%h a=%h t=%b, want 1 500 14 0",
               out_valid, out_data, out_addr, out_type);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_end: v=%b level=%0d ovf=%b, want 0/0/1", out_valid, level, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      grf_we = 1'b1; grf_addr = 5'(i + 1); grf_wdata = 32'hC00 + 32'(i); grf_pc = 32'h7000;
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (level !== 5'd3 || out_data !== 32'hC02) begin
      failures++;
      $display("FAIL pre_reset: level=%0d head=%h, want 3/c02", level, out_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: v=%b level=%0d ovf=%b d=%h, want 0/0/0/0",
               out_valid, level, overflow, out_data);
    end
    tick();
    reset = 1'b0;
    #1;
    grf_we = 1'b1; grf_addr = 5'd3; grf_wdata = 32'hBEEF; grf_pc = 32'h8000;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || level !== 5'd1 || out_data !== 32'hBEEF || out_addr !== 32'd3) begin
      failures++;
      $display("FAIL post_reset_rec: v=%b level=%0d d=%h a=%h, want 1/1/beef/3",
               out_valid, level, out_data, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_drain: valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

`ifdef TRACE_SEQ_EN
  task automatic test_seq();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      grf_we = 1'b1; grf_addr = 5'd1; grf_wdata = 32'(i); grf_pc = 32'h9000;
      tick();
    end
    grf_we = 1'b1; grf_addr = 5'd2; grf_wdata = 32'd15; grf_pc = 32'h9004;
    dm_we  = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD; dm_pc = 32'h9008;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    grf_we = 1'b1; grf_addr = 5'd3; grf_wdata = 32'd16; grf_pc = 32'h900C;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_seq !== 32'(i) || out_data !== 32'(i)) begin
        failures++;
        $display("FAIL seq_%0d: v=%b seq=%0d d=%h, want 1 %0d %h", i, out_valid, out_seq, out_data, i, i);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_dual_push();
    test_filter();
    test_overflow();
    test_reset_mid_drain();
`ifdef TRACE_SEQ_EN
    test_seq();
`else
    do_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
